// File: rtl/mean_row_tx_if.sv
// Zone-mean link: row data in from the mean calculator,
// 42-beat bursts out to the LED FIFO write port.
interface mean_row_tx_if;
    logic       frame_start;
    logic       mean_we;
    logic [5:0] mean_idx;
    logic [7:0] mean_in;
    logic       row_ready;
    logic       data_valid;
    logic [7:0] dout;
    logic       busy;
    logic       overrun;

    modport master (
        output frame_start, mean_we, mean_idx, mean_in, row_ready,
        input  data_valid, dout, busy, overrun
    );

    modport slave (
        input  frame_start, mean_we, mean_idx, mean_in, row_ready,
        output data_valid, dout, busy, overrun
    );
endinterface

// File: rtl/mean_row_tx.sv
// Ping-pong row buffer of zone means; emits means, row index
// and XOR checksum as one unbroken burst per row.
module mean_row_tx #(
    parameter int ZONES   = 40,
    parameter int ROWS    = 24,
    parameter int GAP_CYC = 2
) (
    input logic          wr_clk,
    input logic          rst_n,
    mean_row_tx_if.slave link_io
);
    localparam int IW = $clog2(ZONES);
    localparam int BW = $clog2(ZONES + 2);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int GW = $clog2(GAP_CYC) + 1;
    localparam logic [BW-1:0] LAST = BW'(ZONES + 1);
    localparam logic [BW-1:0] ROWB = BW'(ZONES);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    logic       frame_start;
    logic       mean_we;
    logic [5:0] mean_idx;
    logic [7:0] mean_in;
    logic       row_ready;

    assign frame_start = link_io.frame_start;
    assign mean_we     = link_io.mean_we;
    assign mean_idx    = link_io.mean_idx;
    assign mean_in     = link_io.mean_in;
    assign row_ready   = link_io.row_ready;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [7:0]      csum_q, csum_d;
    logic [RW-1:0]   row_q, row_d;
    logic [RW-1:0]   rlat_q, rlat_d;
    logic            sel_q, sel_d;
    logic            pend_q, pend_d;
    logic            ovr_q, ovr_d;
    logic            dv_q, dv_d;
    logic [7:0]      dout_q, dout_d;
    logic [7:0]      bank_q [2][ZONES];

    logic          wr_en;
    logic          gap_end;
    logic          start;
    logic [BW-1:0] nxt;
    logic [7:0]    snd;
    logic [7:0]    first;
    logic [RW-1:0] row_base;

    assign wr_en   = mean_we && !pend_q && (int'(mean_idx) < ZONES);
    assign gap_end = (state_q == S_GAP) && (gap_q == GW'(GAP_CYC - 1));
    assign start   = ((state_q == S_IDLE) && row_ready)
                   || (gap_end && (pend_q || row_ready));
    assign nxt     = beat_q + 1'b1;
    assign snd     = bank_q[~sel_q][nxt[IW-1:0]];
    assign row_base = frame_start ? '0 : row_q;

    // A write landing on the launch edge must reach beat 0 directly.
    assign first = (wr_en && mean_idx == '0) ? mean_in
                                              : bank_q[sel_q][0];

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int z = 0; z < ZONES; z++)
                    bank_q[b][z] <= '0;
        end else if (wr_en) begin
            bank_q[sel_q][mean_idx[IW-1:0]] <= mean_in;
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            gap_q   <= '0;
            csum_q  <= '0;
            row_q   <= '0;
            rlat_q  <= '0;
            sel_q   <= 1'b0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            dv_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            csum_q  <= csum_d;
            row_q   <= row_d;
            rlat_q  <= rlat_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            dv_q    <= dv_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        csum_d  = csum_q;
        row_d   = row_base;
        rlat_d  = rlat_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        ovr_d   = (ovr_q && !frame_start)
                || (pend_q && (row_ready || mean_we));
        dv_d    = 1'b0;
        dout_d  = '0;
        unique case (state_q)
            S_SEND: begin
                if (row_ready) pend_d = 1'b1;
                if (beat_q == LAST) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end else begin
                    beat_d = nxt;
                    dv_d   = 1'b1;
                    if (nxt < ROWB) begin
                        dout_d = snd;
                        csum_d = csum_q ^ snd;
                    end else if (nxt == ROWB) begin
                        dout_d = 8'(rlat_q);
                    end else begin
                        dout_d = csum_q;
                    end
                end
            end
            S_GAP: begin
                gap_d = gap_q + 1'b1;
                if (row_ready) pend_d = 1'b1;
                if (gap_end) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Launch overrides: swap banks, latch row, present beat 0.
        if (start) begin
            state_d = S_SEND;
            beat_d  = '0;
            sel_d   = ~sel_q;
            pend_d  = 1'b0;
            csum_d  = first;
            dout_d  = first;
            dv_d    = 1'b1;
            rlat_d  = row_base;
            row_d   = (row_base == RW'(ROWS - 1)) ? '0
                                                   : row_base + 1'b1;
        end
    end

    assign link_io.data_valid = dv_q;
    assign link_io.dout       = dout_q;
    assign link_io.busy       = (state_q != S_IDLE) || pend_q;
    assign link_io.overrun    = ovr_q;
endmodule

// File: tb/tb_mean_row_tx.sv
// Scoreboard bench for mean_row_tx: expected bursts queued at
// request time, compared against bursts captured from the port.
module tb_mean_row_tx;
    localparam int ZONES = 40;
    localparam int ROWS  = 24;
    localparam int BL    = ZONES + 2;
    typedef logic [BL*8-1:0] burst_t;

    logic wr_clk = 1'b0;
    logic rst_n  = 1'b0;

    mean_row_tx_if bus ();

    mean_row_tx #(
        .ZONES(ZONES), .ROWS(ROWS), .GAP_CYC(2)
    ) dut (
        .wr_clk (wr_clk),
        .rst_n  (rst_n),
        .link_io(bus)
    );

    always #5 wr_clk = ~wr_clk;

    int n_cmp = 0;
    int n_bad = 0;

    burst_t exp_q[$];
    burst_t got_q[$];
    int     gaps_q[$];
    int     lens_q[$];

    logic [7:0] bank_m [2][ZONES];
    int sel_m  = 0;
    int row_m  = 0;
    bit pend_m = 0;

    burst_t cur;
    int     cur_len = 0;
    int     low_cnt = 0;
    logic   prev_dv = 1'b0;

    always @(negedge wr_clk) begin
        if (!rst_n) begin
            cur_len = 0;
            low_cnt = 0;
            prev_dv = 1'b0;
        end else if (bus.data_valid) begin
            if (!prev_dv) begin
                gaps_q.push_back(low_cnt);
                cur     = '0;
                cur_len = 0;
            end
            if (cur_len < BL) cur[cur_len*8 +: 8] = bus.dout;
            cur_len++;
            prev_dv = 1'b1;
        end else begin
            if (prev_dv) begin
                got_q.push_back(cur);
                lens_q.push_back(cur_len);
                low_cnt = 0;
            end
            low_cnt++;
            prev_dv = 1'b0;
        end
    end

    function automatic burst_t mk(input int b, input int r);
        burst_t     x;
        logic [7:0] c;
        x = '0;
        c = '0;
        for (int k = 0; k < ZONES; k++) begin
            x[k*8 +: 8] = bank_m[b][k];
            c ^= bank_m[b][k];
        end
        x[ZONES*8 +: 8]     = 8'(r);
        x[(ZONES+1)*8 +: 8] = c;
        return x;
    endfunction

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic wr(input int i, input logic [7:0] v, input bit rr);
        bus.mean_we   = 1'b1;
        bus.mean_idx  = 6'(i);
        bus.mean_in   = v;
        bus.row_ready = rr;
        if (!pend_m && i < ZONES) bank_m[sel_m][i] = v;
        tick();
        bus.mean_we   = 1'b0;
        bus.row_ready = 1'b0;
    endtask

    task automatic accept();
        exp_q.push_back(mk(sel_m, row_m));
        sel_m ^= 1;
        row_m = (row_m == ROWS - 1) ? 0 : row_m + 1;
    endtask

    task automatic pulse_rr();
        bus.row_ready = 1'b1;
        tick();
        bus.row_ready = 1'b0;
    endtask

    task automatic pulse_fs();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        row_m = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((bus.busy || bus.data_valid) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s idle-timeout busy=%b", tag, bus.busy);
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        n_cmp++;
        if (bus.data_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_dv got=%b want=0", bus.data_valid);
        end
        n_cmp++;
        if (bus.dout !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_dout got=%h want=00", bus.dout);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_busy got=%b want=0", bus.busy);
        end
        n_cmp++;
        if (bus.overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_ovr got=%b want=0", bus.overrun);
        end
    endtask

    task automatic test_ramp();
        gaps_q.delete();
        lens_q.delete();
        for (int i = 1; i < ZONES; i++) wr(i, 8'(i + 1), 1'b0);
        wr(0, 8'h01, 1'b1);
        accept();
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.dout !== 8'h01) begin
            n_bad++;
            $display("FAIL ramp_first busy=%b dout=%h want 1/01",
                     bus.busy, bus.dout);
        end
        wait_idle("ramp");
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ramp_busy got=%b want=0", bus.busy);
        end
        n_cmp++;
        if (lens_q.size() != 1 || lens_q[0] != BL) begin
            n_bad++;
            $display("FAIL ramp_len got=%p want=%0d", lens_q, BL);
        end
        while (exp_q.size() > 0) begin
            burst_t e;
            burst_t g;
            e = exp_q.pop_front();
            n_cmp++;
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            if (g !== e) begin
                n_bad++;
                $display("FAIL ramp_burst got=%h want=%h", g, e);
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL ramp_extra got=%0d want=0", got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        pulse_fs();
        gaps_q.delete();
        for (int i = 0; i < ZONES; i++) wr(i, 8'(i + 1), 1'b0);
        pulse_rr();
        accept();
        for (int i = 0; i < ZONES; i++) wr(i, 8'hAA, 1'b0);
        pulse_rr();
        accept();
        wait_idle("b2b");
        while (exp_q.size() > 0) begin
            burst_t e;
            burst_t g;
            e = exp_q.pop_front();
            n_cmp++;
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            if (g !== e) begin
                n_bad++;
                $display("FAIL b2b_burst got=%h want=%h", g, e);
            end
        end
        n_cmp++;
        if (got_q.size() != 0 || gaps_q.size() != 2 || gaps_q[1] != 2) begin
            n_bad++;
            $display("FAIL b2b_gap extra=%0d gaps=%p want gap 2",
                     got_q.size(), gaps_q);
        end
        n_cmp++;
        if (bus.overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ovr got=%b want=0", bus.overrun);
        end
    endtask

    task automatic test_overrun();
        pulse_fs();
        pulse_rr();
        accept();
        repeat (5) tick();
        pulse_rr();
        accept();
        pend_m = 1;
        n_cmp++;
        if (bus.overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_early got=%b want=0", bus.overrun);
        end
        repeat (5) tick();
        pulse_rr();
        n_cmp++;
        if (bus.overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_set got=%b want=1", bus.overrun);
        end
        wait_idle("ovr");
        pend_m = 0;
        while (exp_q.size() > 0) begin
            burst_t e;
            burst_t g;
            e = exp_q.pop_front();
            n_cmp++;
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            if (g !== e) begin
                n_bad++;
                $display("FAIL ovr_burst got=%h want=%h", g, e);
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL ovr_count extra=%0d want=0", got_q.size());
        end
        pulse_fs();
        n_cmp++;
        if (bus.overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_clear got=%b want=0", bus.overrun);
        end
    endtask

    task automatic test_frozen();
        wr(5, 8'h33, 1'b0);
        pulse_rr();
        accept();
        wr(5, 8'h44, 1'b0);
        pulse_rr();
        accept();
        pend_m = 1;
        wr(5, 8'h77, 1'b0);
        n_cmp++;
        if (bus.overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL frz_ovr got=%b want=1", bus.overrun);
        end
        wait_idle("frz");
        pend_m = 0;
        while (exp_q.size() > 0) begin
            burst_t e;
            burst_t g;
            e = exp_q.pop_front();
            n_cmp++;
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            if (g !== e) begin
                n_bad++;
                $display("FAIL frz_burst got=%h want=%h", g, e);
            end
        end
        pulse_fs();
    endtask

    task automatic test_wrap_frame();
        pulse_fs();
        for (int r = 0; r < ROWS + 1 + 7; r++) begin
            if (r == ROWS + 1) pulse_fs();
            wr(int'($urandom_range(0, ZONES - 1)), 8'($urandom), 1'b0);
            pulse_rr();
            accept();
            wait_idle("wrap");
        end
        wr(3, 8'h5C, 1'b0);
        pulse_rr();
        accept();
        repeat (10) tick();
        pulse_fs();
        wait_idle("frame");
        pulse_rr();
        accept();
        wait_idle("frame2");
        while (exp_q.size() > 0) begin
            burst_t e;
            burst_t g;
            e = exp_q.pop_front();
            n_cmp++;
            g = (got_q.size() > 0) ? got_q.pop_front() : '0;
            if (g !== e) begin
                n_bad++;
                $display("FAIL wrap_burst row=%0d got=%h want=%h",
                         e[ZONES*8 +: 8], g, e);
            end
        end
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL wrap_extra got=%0d want=0", got_q.size());
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < ZONES; i++) wr(i, 8'(8'h80 + i), 1'b0);
        pulse_rr();
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.data_valid !== 1'b0 || bus.dout !== 8'h00) begin
            n_bad++;
            $display("FAIL arst_out dv=%b dout=%h want 0/00",
                     bus.data_valid, bus.dout);
        end
        for (int b = 0; b < 2; b++)
            for (int z = 0; z < ZONES; z++) bank_m[b][z] = '0;
        sel_m  = 0;
        row_m  = 0;
        pend_m = 0;
        exp_q.delete();
        got_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        pulse_rr();
        accept();
        wait_idle("arst");
        while (exp_q.size() > 0) begin
            burst_t e;
            burst_t g;
            e = exp_q.pop_front();
            n_cmp++;
            g = (got_q.size() > 0) ? got_q.pop_front() : {BL{8'hFF}};
            if (g !== e) begin
                n_bad++;
                $display("FAIL arst_burst got=%h want=%h", g, e);
            end
        end
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.mean_we     = 1'b0;
        bus.mean_idx    = '0;
        bus.mean_in     = '0;
        bus.row_ready   = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int z = 0; z < ZONES; z++) bank_m[b][z] = '0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_ramp();
        test_back_to_back();
        test_overrun();
        test_frozen();
        test_wrap_frame();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mean_row_tx.md
# mean_row_tx

Write-side producer for the zone-mean link into the LED FIFO port. It collects one row of per-zone 8-bit brightness means from the mean calculator into a ping-pong register bank. On each `row_ready` it emits a contiguous 42-beat burst (40 means + row index + XOR checksum) on `data_valid`/`dout`. `dout` drives the port's `din` directly. The port writes beats 0..39 and counts all 42 beats, so the burst must never break mid-row.

## Interface
- `ZONES`, 40: zone means per row; beats 0..ZONES-1.
- `ROWS`, 24: rows per frame; row index wraps after ROWS-1.
- `GAP_CYC`, 2: minimum idle cycles with data_valid low between bursts (≥1).
- `wr_clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_start` in 1: one-cycle pulse; clears row counter and `overrun`.
- `mean_we` in 1: write strobe for fill bank.
- `mean_idx` in 6: zone index; values ≥ ZONES ignored.
- `mean_in` in 8: zone mean value.
- `row_ready` in 1: one-cycle pulse; fill bank complete, request send.
- `data_valid` out 1: burst valid, registered.
- `dout` out 8: burst byte, registered.
- `busy` out 1: high in SEND or GAP, or when a request is pending.
- `overrun` out 1: sticky error flag.

## Operation
- Two banks of ZONES×8 regs, `fill_sel` selects the write bank; the other bank is the send bank.
- `mean_we` writes `bank[fill_sel][mean_idx] <= mean_in`.
- FSM states: IDLE, SEND, GAP.
- IDLE + `row_ready`:
  - toggle `fill_sel`;
  - clear checksum accumulator;
  - beat=0; go to SEND.
- SEND, beat 0..ZONES-1:
  - dout = send_bank[beat]; XOR into checksum.
  - beat ZONES: dout = row_idx (zero-extended).
  - beat ZONES+1: dout = checksum of the ZONES means.
  - after beat ZONES+1: row_idx increments (ROWS-1 → 0); go to GAP.
- GAP counts GAP_CYC cycles with data_valid=0, dout=0. At its end:
  - pending set: swap, clear pending, go to SEND;
  - otherwise go to IDLE.
- `row_ready` while in SEND/GAP:
  - pending=0: set pending. The fill bank is now frozen; `mean_we` while pending is dropped and sets `overrun`.
  - pending=1: request dropped; set `overrun`.
- `mean_we` and `row_ready` in the same cycle (IDLE): write lands in the bank being swapped out and is included in that row.
- `frame_start`:
  - row_idx <= 0 and `overrun` <= 0.
  - Mid-burst, the current burst keeps its latched row index; the next burst carries 0.
  - `frame_start` and an overrun event in the same cycle: `overrun` = 1.
- Reset mid-burst aborts immediately. After reset: data_valid=0, dout=0, busy=0, overrun=0, state IDLE, pending=0, fill_sel=0, row_idx=0, all bank entries 0.

## Timing
- `row_ready` sampled high at edge T in IDLE: data_valid high for cycles T+1..T+ZONES+2 (42 cycles), contiguous with no holes.
- dout at T+1+k is beat k.
- data_valid low for exactly GAP_CYC cycles after the last beat, then the pending burst starts.
- Back-to-back throughput: one row per ZONES+2+GAP_CYC cycles (44 default).
- `busy` timing:
  - asserted the cycle after the accepting edge;
  - deasserted the cycle IDLE is re-entered;
  - a request accepted in IDLE is never lost.
- `mean_idx` checksum width: 8-bit XOR; row_idx width ceil(log2(ROWS)), zero-padded to 8.

## Test plan
- Ramp row:
  - Stimulus: write mean[i]=i+1 for i=0..39, then `row_ready`.
  - Response: data_valid high for 42 consecutive cycles; dout = 1..40, then 0x00 (row 0), then 0x28.
  - Response: then 2 low cycles; busy low afterwards.
- Back-to-back:
  - Stimulus: second row (all 0xAA) written, `row_ready` mid-burst.
  - Response: first burst unchanged; exactly 2 gap cycles; second burst 40×0xAA, row byte 0x01, checksum 0x00.
  - Response: overrun=0.
- Overrun:
  - Stimulus: three `row_ready` pulses within one burst.
  - Response: overrun=1 after the third; only two bursts emitted.
  - Stimulus: `frame_start`.
  - Response: overrun=0.
- Frozen bank:
  - Stimulus: `mean_we` idx 5 value 0x77 while pending.
  - Response: write dropped (pending burst beat 5 holds prior value); overrun=1.
- Wrap and frame:
  - Stimulus: send 25 rows.
  - Response: row bytes 0..23, then 0.
  - Stimulus: `frame_start` during a burst of row 7.
  - Response: that burst shows 7; next burst shows 0.
- Reset:
  - Stimulus: rst_n low at beat 20.
  - Response: data_valid=0, dout=0 asynchronously; after release, a new `row_ready` sends all-zero means with row 0 and checksum 0.
